// File: rtl/ahb_lite_interconnect.sv
// ahb_lite_interconnect
//   Single-master AHB-lite interconnect with an N-slave address map.
//   Each slave has a programmable base/mask pair. The lowest matching
//   index wins. Addresses that match no slave go to a built-in default
//   slave, which gives a two-cycle ERROR response and logs the error.
//
// Parameters
//   NSLAVE    number of slave ports (1..16)
//   DATA_W    data bus width
//   SLV_BASE  flattened base addresses, slave i at [32i+31:32i]
//   SLV_MASK  flattened decode masks, same layout
//
// Ports
//   HCLK, HRESETn          bus clock, asynchronous active-low reset
//   HADDR/HTRANS/HWRITE    master address phase
//   HRDATA/HREADY/HRESP    data-phase response to the master
//                          (HREADY also feeds every slave's HREADY input)
//   HSEL_S                 one-hot slave select, combinational from HADDR
//   HADDR_D/HWRITE_D       address/direction held for the data phase
//   HRDATA_S/HREADYOUT_S/HRESP_S  per-slave responses, flattened
//   ERR_CLR                synchronous clear of the error counter
//   ERR_CNT/ERR_ADDR       saturating error count, last error address
module ahb_lite_interconnect #(
  parameter int                   NSLAVE   = 4,
  parameter int                   DATA_W   = 32,
  parameter logic [NSLAVE*32-1:0] SLV_BASE = '0,
  parameter logic [NSLAVE*32-1:0] SLV_MASK = '0
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [31:0]                HADDR,
  input  logic [1:0]                 HTRANS,
  input  logic                       HWRITE,
  output logic [DATA_W-1:0]          HRDATA,
  output logic                       HREADY,
  output logic                       HRESP,
  output logic [NSLAVE-1:0]          HSEL_S,
  output logic [31:0]                HADDR_D,
  output logic                       HWRITE_D,
  input  logic [NSLAVE*DATA_W-1:0]   HRDATA_S,
  input  logic [NSLAVE-1:0]          HREADYOUT_S,
  input  logic [NSLAVE-1:0]          HRESP_S,
  input  logic                       ERR_CLR,
  output logic [7:0]                 ERR_CNT,
  output logic [31:0]                ERR_ADDR
);

  localparam int IDX_W = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_1    = 2'd1,
    E_2    = 2'd2
  } err_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;

  logic             vld_p1;
  logic             dflt_p1;
  logic [IDX_W-1:0] sidx_p1;
  logic [31:0]      haddr_p1;
  logic             hwrite_p1;

  err_state_e       err_state, err_state_nxt;
  logic             err_ready, err_resp, err_accept;

  logic             hready_int;
  logic [7:0]       err_cnt;
  logic [31:0]      err_addr;

  logic             unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

  // ---- stage p0: address-phase decode --------------------------------
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (!dec_hit &&
          ((HADDR & SLV_MASK[32*i +: 32]) ==
           (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32]))) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
  end

  assign HSEL_S = dec_hit ? (NSLAVE'(1) << dec_idx) : '0;

  // ---- stage p1: data-phase select, held through wait states ---------
  // vld_p1 marks an active transfer in the data phase; with dflt_p1 it
  // goes to the default slave, otherwise to slave sidx_p1.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vld_p1    <= 1'b0;
      dflt_p1   <= 1'b0;
      sidx_p1   <= '0;
      haddr_p1  <= '0;
      hwrite_p1 <= 1'b0;
    end else if (hready_int) begin
      vld_p1    <= HTRANS[1];
      dflt_p1   <= HTRANS[1] & ~dec_hit;
      sidx_p1   <= dec_idx;
      haddr_p1  <= HADDR;
      hwrite_p1 <= HWRITE;
    end
  end

  assign HADDR_D  = haddr_p1;
  assign HWRITE_D = hwrite_p1;

  always_comb begin
    HRDATA     = '0;
    hready_int = 1'b1;
    HRESP      = 1'b0;
    if (vld_p1) begin
      if (dflt_p1) begin
        hready_int = err_ready;
        HRESP      = err_resp;
      end else begin
        HRDATA     = HRDATA_S[sidx_p1*DATA_W +: DATA_W];
        hready_int = HREADYOUT_S[sidx_p1];
        HRESP      = HRESP_S[sidx_p1];
      end
    end
  end

  assign HREADY = hready_int;

  // Default slave: E_1 stalls with ERROR, E_2 completes the ERROR. A new
  // unmapped transfer accepted in E_2 re-enters E_1 without a gap.
  assign err_accept = hready_int & HTRANS[1] & ~dec_hit;
  assign err_ready  = (err_state != E_1);
  assign err_resp   = (err_state != E_IDLE);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) err_state <= E_IDLE;
    else          err_state <= err_state_nxt;
  end

  always_comb begin
    err_state_nxt = err_state;
    unique case (err_state)
      E_IDLE:  if (err_accept) err_state_nxt = E_1;
      E_1:     err_state_nxt = E_2;
      E_2:     err_state_nxt = err_accept ? E_1 : E_IDLE;
      default: err_state_nxt = E_IDLE;
    endcase
  end

  // A clear coinciding with a new error leaves exactly that error counted.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_cnt  <= 8'd0;
      err_addr <= 32'd0;
    end else if (err_accept) begin
      err_cnt  <= ERR_CLR ? 8'd1 : sat_inc8(err_cnt);
      err_addr <= HADDR;
    end else if (ERR_CLR) begin
      err_cnt  <= 8'd0;
    end
  end

  assign ERR_CNT  = err_cnt;
  assign ERR_ADDR = err_addr;

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
`timescale 1ns/1ps
module tb_ahb_lite_interconnect;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam logic [NS*32-1:0] BASE = {32'h1FC00000, 32'h1F800000, 32'h00000000, 32'h1FC00000};
  localparam logic [NS*32-1:0] MASK = {32'hFFC00000, 32'h1FC00000, 32'h10000000, 32'h1FC00000};

  // Reference address map, slave 0 first.
  localparam logic [31:0] M_BASE [NS] = '{32'h1FC00000, 32'h00000000, 32'h1F800000, 32'h1FC00000};
  localparam logic [31:0] M_MASK [NS] = '{32'h1FC00000, 32'h10000000, 32'h1FC00000, 32'hFFC00000};

  localparam int T_NONE = -2;
  localparam int T_DEF  = -1;

  logic              HCLK, HRESETn;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [DW-1:0]     HRDATA;
  logic              HREADY, HRESP;
  logic [NS-1:0]     HSEL_S;
  logic [31:0]       HADDR_D;
  logic              HWRITE_D;
  logic [NS*DW-1:0]  HRDATA_S;
  logic [NS-1:0]     HREADYOUT_S, HRESP_S;
  logic              ERR_CLR;
  logic [7:0]        ERR_CNT;
  logic [31:0]       ERR_ADDR;

  ahb_lite_interconnect #(
    .NSLAVE(NS), .DATA_W(DW), .SLV_BASE(BASE), .SLV_MASK(MASK)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .HSEL_S(HSEL_S),
    .HADDR_D(HADDR_D), .HWRITE_D(HWRITE_D), .HRDATA_S(HRDATA_S),
    .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .ERR_CLR(ERR_CLR),
    .ERR_CNT(ERR_CNT), .ERR_ADDR(ERR_ADDR)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    int          waits;
    bit          serr;
    bit          clr;
  } stim_t;

  // One expected data-phase cycle: target (slave index, T_DEF or T_NONE)
  // and the HREADY/HRESP the master must see in that cycle.
  typedef struct {
    int   tgt;
    logic ready;
    logic resp;
  } resp_t;

  stim_t stim_q[$];
  resp_t dq[$];     // drives the slave models
  resp_t exp_q[$];  // consumed by the monitor

  int checks = 0;
  int failures = 0;

  stim_t       cur;
  logic [31:0] m_haddr_d;
  logic        m_hwrite_d;
  logic [7:0]  m_cnt;
  logic [31:0] m_eaddr;
  bit          rnd_en;
  bit          mon_en;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & M_MASK[i]) == (M_BASE[i] & M_MASK[i])) return i;
    return T_DEF;
  endfunction

  function automatic stim_t mk(input logic [31:0] a, input logic [1:0] tr, input logic w,
                               input int waits, input bit serr, input bit clr);
    stim_t s;
    s.addr = a; s.trans = tr; s.write = w; s.waits = waits; s.serr = serr; s.clr = clr;
    return s;
  endfunction

  task automatic next_stim(output stim_t s);
    int r;
    s = mk(32'h0, 2'd0, 1'b0, 0, 1'b0, 1'b0);
    if (stim_q.size() > 0) begin
      s = stim_q.pop_front();
    end else if (rnd_en) begin
      r = $urandom_range(0, 5);
      case (r)
        0:       s.addr = 32'hBFC00000 | ($urandom & 32'h0000FFFC);
        1:       s.addr = 32'h80000000 | ($urandom & 32'h0FFFFFFC);
        2:       s.addr = 32'hBF800000 | ($urandom & 32'h003FFFFC);
        3:       s.addr = 32'h30000000 | ($urandom & 32'h00000FFC);
        4:       s.addr = 32'h1FC00000 | ($urandom & 32'h003FFFFC);
        default: s.addr = $urandom;
      endcase
      s.trans = 2'($urandom_range(0, 3));
      s.write = 1'($urandom_range(0, 1));
      s.waits = $urandom_range(0, 3);
      s.serr  = ($urandom_range(0, 7) == 0);
      s.clr   = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic apply_cur();
    HADDR = cur.addr; HTRANS = cur.trans; HWRITE = cur.write; ERR_CLR = cur.clr;
  endtask

  task automatic push_resp(input int tgt, input logic rdy, input logic rsp);
    resp_t e;
    e.tgt = tgt; e.ready = rdy; e.resp = rsp;
    dq.push_back(e);
    exp_q.push_back(e);
  endtask

  // Expected response sequence of one accepted transfer.
  task automatic push_sched(input stim_t s, input int tgt);
    if (tgt == T_NONE) begin
      push_resp(tgt, 1'b1, 1'b0);
    end else if (tgt == T_DEF) begin
      push_resp(tgt, 1'b0, 1'b1);
      push_resp(tgt, 1'b1, 1'b1);
    end else begin
      for (int k = 0; k < s.waits; k++) push_resp(tgt, 1'b0, 1'b0);
      if (s.serr) begin
        push_resp(tgt, 1'b0, 1'b1);
        push_resp(tgt, 1'b1, 1'b1);
      end else begin
        push_resp(tgt, 1'b1, 1'b0);
      end
    end
  endtask

  // Unselected slaves drive noise; the slave owning the data phase
  // follows the expected schedule.
  task automatic drive_slaves();
    for (int i = 0; i < NS; i++) begin
      HRDATA_S[i*DW +: DW] = $urandom;
      HREADYOUT_S[i] = 1'($urandom_range(0, 1));
      HRESP_S[i]     = 1'($urandom_range(0, 1));
    end
    if (dq.size() > 0 && dq[0].tgt >= 0) begin
      HREADYOUT_S[dq[0].tgt] = dq[0].ready;
      HRESP_S[dq[0].tgt]     = dq[0].resp;
    end
  endtask

  task automatic step();
    logic mready;
    int   tgt;
    bit   new_err;
    drive_slaves();
    mready = (dq.size() == 0) ? 1'b1 : dq[0].ready;
    @(posedge HCLK);
    #1;
    if (dq.size() > 0) dq.delete(0);
    new_err = 1'b0;
    if (mready) begin
      tgt = cur.trans[1] ? ref_decode(cur.addr) : T_NONE;
      push_sched(cur, tgt);
      m_haddr_d  = cur.addr;
      m_hwrite_d = cur.write;
      new_err    = (tgt == T_DEF);
    end
    if (cur.clr) m_cnt = 8'd0;
    if (new_err) begin
      m_cnt   = (int'(m_cnt) + 1 > 255) ? 8'd255 : 8'(int'(m_cnt) + 1);
      m_eaddr = cur.addr;
    end
    if (mready) begin
      next_stim(cur);
      apply_cur();
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (stim_q.size() > 0 && guard < 5000) begin
      step();
      guard++;
    end
    chk("drain_bound", 32'(stim_q.size()), 32'd0);
    repeat (6) step();
  endtask

  task automatic model_reset();
    m_haddr_d = 32'h0; m_hwrite_d = 1'b0; m_cnt = 8'd0; m_eaddr = 32'h0;
    dq.delete(); exp_q.delete(); stim_q.delete();
    cur = mk(32'h0, 2'd0, 1'b0, 0, 1'b0, 1'b0);
    apply_cur();
    push_resp(T_NONE, 1'b1, 1'b0);
    exp_q.delete();
  endtask

  task automatic step_until_stall(input int tgt, input string nm);
    bit found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (dq.size() > 0 && dq[0].tgt == tgt && dq[0].ready == 1'b0) found = 1'b1;
    end
    chk(nm, 32'(found), 32'd1);
  endtask

  task automatic mid_reset(input string nm);
    mon_en = 1'b0;
    #2;
    HRESETn = 1'b0;
    #1;
    chk({nm, "_hready"}, 32'(HREADY), 32'd1);
    chk({nm, "_hresp"},  32'(HRESP), 32'd0);
    chk({nm, "_hrdata"}, HRDATA, 32'd0);
    chk({nm, "_errcnt"}, 32'(ERR_CNT), 32'd0);
    chk({nm, "_haddr_d"}, HADDR_D, 32'd0);
    model_reset();
    @(negedge HCLK);
    #1;
    HRESETn = 1'b1;
    mon_en = 1'b1;
  endtask

  // Scoreboard monitor: one expected response per data-phase cycle.
  resp_t          me;
  int             md;
  logic [31:0]    exp_rd;
  logic [NS-1:0]  exp_sel;

  initial begin
    forever begin
      @(negedge HCLK);
      if (mon_en && exp_q.size() > 0) begin
        me = exp_q.pop_front();
        exp_rd = (me.tgt >= 0) ? HRDATA_S[me.tgt*DW +: DW] : 32'h0;
        chk("hready", 32'(HREADY), 32'(me.ready));
        chk("hresp",  32'(HRESP),  32'(me.resp));
        chk("hrdata", HRDATA, exp_rd);
        md = ref_decode(HADDR);
        exp_sel = (md >= 0) ? (NS'(1) << md) : '0;
        chk("hsel", 32'(HSEL_S), 32'(exp_sel));
        chk("haddr_d", HADDR_D, m_haddr_d);
        chk("hwrite_d", 32'(HWRITE_D), 32'(m_hwrite_d));
        chk("err_cnt", 32'(ERR_CNT), 32'(m_cnt));
        chk("err_addr", ERR_ADDR, m_eaddr);
      end
    end
  end

  initial begin
    HRESETn = 1'b0; HADDR = 32'h0; HTRANS = 2'd0; HWRITE = 1'b0; ERR_CLR = 1'b0;
    HRDATA_S = '0; HREADYOUT_S = '1; HRESP_S = '0;
    mon_en = 1'b0; rnd_en = 1'b0;
    model_reset();
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_hready", 32'(HREADY), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_haddr_d", HADDR_D, 32'd0);
    chk("rst_hwrite_d", 32'(HWRITE_D), 32'd0);
    chk("rst_err_cnt", 32'(ERR_CNT), 32'd0);
    chk("rst_err_addr", ERR_ADDR, 32'd0);

    HADDR = 32'hBFC00010; #1; chk("hsel_boot", 32'(HSEL_S), 32'h1);
    HADDR = 32'h80000100; #1; chk("hsel_ram", 32'(HSEL_S), 32'h2);
    HADDR = 32'hBF800004; #1; chk("hsel_s2", 32'(HSEL_S), 32'h4);
    HADDR = 32'h1FC00000; #1; chk("hsel_overlap", 32'(HSEL_S), 32'h1);
    HADDR = 32'h30000000; #1; chk("hsel_unmapped", 32'(HSEL_S), 32'h0);
    HADDR = 32'h0;

    @(negedge HCLK);
    #1;
    HRESETn = 1'b1;
    mon_en = 1'b1;

    // zero-wait read of boot ROM
    stim_q.push_back(mk(32'hBFC00010, 2'd2, 1'b0, 0, 1'b0, 1'b0));
    drain();

    // three-cycle slave wait with a pipelined address to slave 2
    stim_q.push_back(mk(32'h80000100, 2'd2, 1'b1, 3, 1'b0, 1'b0));
    stim_q.push_back(mk(32'hBF800004, 2'd2, 1'b0, 0, 1'b0, 1'b0));
    drain();

    // unmapped NONSEQ then IDLE to the same address
    stim_q.push_back(mk(32'h30000000, 2'd2, 1'b0, 0, 1'b0, 1'b0));
    stim_q.push_back(mk(32'h30000000, 2'd0, 1'b0, 0, 1'b0, 1'b0));
    drain();
    chk("err1_cnt", 32'(ERR_CNT), 32'd1);
    chk("err1_addr", ERR_ADDR, 32'h30000000);

    // back-to-back unmapped, first one alongside a clear
    stim_q.push_back(mk(32'h30000004, 2'd2, 1'b0, 0, 1'b0, 1'b1));
    stim_q.push_back(mk(32'h30000008, 2'd3, 1'b1, 0, 1'b0, 1'b0));
    drain();
    chk("b2b_cnt", 32'(ERR_CNT), 32'd2);
    chk("b2b_addr", ERR_ADDR, 32'h30000008);

    // saturation
    for (int i = 0; i < 300; i++)
      stim_q.push_back(mk(32'h30001000 + 32'(i*4), 2'd2, 1'b0, 0, 1'b0, 1'b0));
    drain();
    chk("sat_cnt", 32'(ERR_CNT), 32'd255);
    chk("sat_addr", ERR_ADDR, 32'h300014AC);

    // clear coinciding with an error
    stim_q.push_back(mk(32'h30002000, 2'd2, 1'b0, 0, 1'b0, 1'b1));
    drain();
    chk("clr_err_cnt", 32'(ERR_CNT), 32'd1);
    chk("clr_err_addr", ERR_ADDR, 32'h30002000);

    // reset during E_1
    stim_q.push_back(mk(32'h30003000, 2'd2, 1'b0, 0, 1'b0, 1'b0));
    step_until_stall(T_DEF, "reach_e1");
    mid_reset("rst_e1");

    // reset during a slave wait
    stim_q.push_back(mk(32'h80000200, 2'd2, 1'b1, 5, 1'b0, 1'b0));
    step_until_stall(1, "reach_wait");
    mid_reset("rst_wait");

    // normal traffic after reset
    stim_q.push_back(mk(32'hBFC00020, 2'd2, 1'b0, 0, 1'b0, 1'b0));
    stim_q.push_back(mk(32'hBF800010, 2'd2, 1'b1, 1, 1'b0, 1'b0));
    drain();

    // randomized traffic
    rnd_en = 1'b1;
    repeat (3000) step();
    rnd_en = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
